id_decode_stage: RTL and testbench
==================================

Name: id_decode_stage

Overview:
- Parametrised, registered instruction-decode stage; the successor to the current combinational opcode decoder.
- Sits between the IF buffer and EX.
- Decodes the opcode class, write-enable and register fields, and sign-extends the immediate.
- Holds the ID/EX pipeline register under a valid/ready handshake, inserts load-use bubbles, halts on undefined opcodes until flushed, and counts stall cycles.

Parameters:
- W_INST, 32, instruction width.
- W_OPC, 7, opcode width.
- W_RA, 5, register-address width.
- EN_EXT, 0, 1 = opcodes 0x20-0x23 decode as class EXT; 0 = they decode as reserved.
- W_CNT, 16, stall-counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- inst_i  in  W_INST  instruction from IF.
- inst_vld_i  in  1  inst_i valid.
- id_rdy_o  out  1  ID accepts inst_i this cycle (combinational).
- flush_i  in  1  branch/exception flush.
- ex_rdy_i  in  1  EX accepts ID/EX contents.
- vld_o  out  1  ID/EX valid.
- cls_o  out  8  one-hot {int, logic, shift, set, ld, st, br, ext}; all-zero for und/rsv.
- we_o  out  1  register write enable.
- rd_o  out  W_RA  destination register.
- rs1_o  out  W_RA  source register 1.
- rs2_o  out  W_RA  source register 2.
- imm_o  out  W_INST  sign-extended immediate.
- imm_sel_o  out  1  immediate replaces rs2.
- rsv_o  out  1  reserved opcode.
- und_o  out  1  undefined opcode.
- stall_o  out  1  load-use hazard this cycle (combinational).
- stall_cnt_o  out  W_CNT  saturating count of hazard cycles.

Behaviour:
- Instruction fields:
  - I = inst[W_INST-1]
  - opc = inst[W_INST-2 -: W_OPC]
  - rd next W_RA bits below opc, then rs1.
  - rs2 = top W_RA bits of the remainder.
  - imm = whole remainder, W_IMM = W_INST-1-W_OPC-2*W_RA (14 at defaults), sign-extended.
- Opcode map (cls, we):
  - 0x00-0x07 int, we=1, except 0x04 we=0.
  - 0x08-0x0D shift, we=1.
  - 0x10-0x13 logic, we=1.
  - 0x16-0x17 set, we=1.
  - 0x18 ld, we=1.
  - 0x19 st, we=0.
  - 0x1C-0x1F br, we=0.
  - 0x20-0x23: ext, we=1 if EN_EXT; otherwise rsv_o=1, we=0.
  - Any other value: und_o=1, we=0.
- rs2 is used only when I=0 and class is int/shift/logic/set/st/br.
- Reset: all registered outputs 0, stall_cnt_o 0, FSM=RUN. id_rdy_o and stall_o are forced 0 while rst=1.
- Hazard = inst_vld_i & vld_o & cls_o[ld] & rd_o!=0 & (rd_o==rs1 | (rs2 used & rd_o==rs2)).
- id_rdy_o = !rst & !flush_i & state==RUN & (!vld_o | ex_rdy_i) & !hazard.
- stall_o = hazard & state==RUN & !flush_i.
- Latency: an instruction accepted at edge N appears on the outputs after edge N (one cycle).
- Register update, in priority order:
  1. rst.
  2. flush_i: vld_o<=0, FSM->RUN, incoming instruction dropped.
  3. Accept: load decoded fields, vld_o<=1.
  4. vld_o & ex_rdy_i & no accept: vld_o<=0 (bubble; covers the hazard case).
  5. Otherwise hold all outputs.
- FSM:
  - RUN -> HALT when an und or rsv instruction is accepted; that instruction is still presented with its flag set.
  - HALT: id_rdy_o=0. Leaves only via flush_i or rst.
- Load-use: a dependent instruction sees exactly one bubble when ex_rdy_i=1. If ex_rdy_i=0, everything holds; stall_o may stay high and count again.
- stall_cnt_o increments when stall_o=1, saturates at all-ones, and clears only on rst.
- rd==0 never triggers a hazard.
- Simultaneous flush_i and hazard: flush wins, stall_o=0, no count.

Test Plan:
- Reset, then 0x00184400 (add r3,r1,r2) valid, ex_rdy_i=1 -> next cycle vld_o=1, cls_o=0x80, we_o=1, rd/rs1/rs2=3/1/2, imm_sel_o=0.
- 0x98284004 (ld r5,[r1+4]) then 0x00314400 (add r6,r5,r2) back-to-back, ex_rdy_i=1 -> ld on outputs; one cycle with stall_o=1 and vld_o=0; then add valid; stall_cnt_o=1.
- Same ld then add with rd=0 (0x98004004 then 0x00014400) -> no stall, stall_cnt_o unchanged.
- ex_rdy_i=0 with vld_o=1 -> id_rdy_o=0 and outputs frozen for 5 cycles; ex_rdy_i=1 -> drains; next instruction accepted.
- 0x14000000 (opc 0x14) -> und_o=1, cls_o=0, then id_rdy_o=0 indefinitely; flush_i pulse -> vld_o=0, id_rdy_o=1 next cycle. EN_EXT=0 with opc 0x20 -> rsv_o=1, same halt; EN_EXT=1 -> cls_o=0x01, we_o=1.
- Immediate 0x3FFF in the low 14 bits with I=1 -> imm_o=0xFFFFFFFF, imm_sel_o=1. Force W_CNT=2 with 5 hazard cycles -> stall_cnt_o saturates at 3.

Source files
------------

// File: rtl/id_decode_stage.sv
// id_decode_stage: registered instruction-decode stage between the IF buffer and EX.
//
// Decodes the opcode class, the write enable, the register fields and the
// sign-extended immediate. The result is held in an ID/EX register under a
// valid/ready handshake. The stage also:
//   - inserts a one-cycle bubble on a load-use hazard,
//   - halts after accepting an undefined or reserved opcode until flush_i,
//   - keeps a saturating count of hazard (stall) cycles.
//
// Instruction layout (MSB first): I | opc | rd | rs1 | imm (rs2 = top W_RA bits of imm)
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   inst_i          instruction from IF
//   inst_vld_i      inst_i valid
//   id_rdy_o        ID accepts inst_i this cycle (combinational)
//   flush_i         branch/exception flush; drops the ID/EX contents and the incoming instruction
//   ex_rdy_i        EX accepts the ID/EX contents
//   vld_o           ID/EX valid
//   cls_o           one-hot {int, logic, shift, set, ld, st, br, ext}; zero for und/rsv
//   we_o            register write enable
//   rd_o            destination register
//   rs1_o, rs2_o    source registers
//   imm_o           sign-extended immediate
//   imm_sel_o       immediate replaces rs2
//   rsv_o, und_o    reserved / undefined opcode flags
//   stall_o         load-use hazard this cycle (combinational)
//   stall_cnt_o     saturating count of hazard cycles
module id_decode_stage #(
    parameter int unsigned W_INST = 32,
    parameter int unsigned W_OPC  = 7,
    parameter int unsigned W_RA   = 5,
    parameter int unsigned EN_EXT = 0,
    parameter int unsigned W_CNT  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [W_INST-1:0] inst_i,
    input  logic              inst_vld_i,
    output logic              id_rdy_o,
    input  logic              flush_i,
    input  logic              ex_rdy_i,
    output logic              vld_o,
    output logic [7:0]        cls_o,
    output logic              we_o,
    output logic [W_RA-1:0]   rd_o,
    output logic [W_RA-1:0]   rs1_o,
    output logic [W_RA-1:0]   rs2_o,
    output logic [W_INST-1:0] imm_o,
    output logic              imm_sel_o,
    output logic              rsv_o,
    output logic              und_o,
    output logic              stall_o,
    output logic [W_CNT-1:0]  stall_cnt_o
);

    localparam int unsigned W_IMM = W_INST - 1 - W_OPC - 2 * W_RA;

    // Bit positions inside cls_o
    localparam int unsigned C_INT   = 7;
    localparam int unsigned C_LOGIC = 6;
    localparam int unsigned C_SHIFT = 5;
    localparam int unsigned C_SET   = 4;
    localparam int unsigned C_LD    = 3;
    localparam int unsigned C_ST    = 2;
    localparam int unsigned C_BR    = 1;
    localparam int unsigned C_EXT   = 0;

    // Classes whose register form reads rs2: int, logic, shift, set, st, br
    localparam logic [7:0] RS2_CLS = 8'b1111_0110;

    typedef enum logic [0:0] {StRun, StHalt} state_e;

    state_e state_q, state_d;

    // Field extraction from the incoming instruction
    logic              f_i;
    logic [W_OPC-1:0]  f_opc;
    logic [W_RA-1:0]   f_rd, f_rs1, f_rs2;
    logic [W_INST-1:0] f_imm;
    logic [31:0]       opc_n;

    assign f_i   = inst_i[W_INST-1];
    assign f_opc = inst_i[W_INST-2 -: W_OPC];
    assign f_rd  = inst_i[W_IMM+W_RA +: W_RA];
    assign f_rs1 = inst_i[W_IMM +: W_RA];
    assign f_rs2 = inst_i[W_IMM-1 -: W_RA];
    assign f_imm = {{(W_INST-W_IMM){inst_i[W_IMM-1]}}, inst_i[W_IMM-1:0]};
    assign opc_n = 32'(f_opc);

    // Opcode decode
    logic [7:0] dec_cls;
    logic       dec_we, dec_rsv, dec_und, rs2_used;

    always_comb begin
        dec_cls = '0;
        dec_we  = 1'b0;
        dec_rsv = 1'b0;
        dec_und = 1'b0;
        if (opc_n <= 32'h07) begin
            dec_cls[C_INT] = 1'b1;
            dec_we         = (opc_n != 32'h04);
        end else if (opc_n <= 32'h0D) begin
            dec_cls[C_SHIFT] = 1'b1;
            dec_we           = 1'b1;
        end else if (opc_n >= 32'h10 && opc_n <= 32'h13) begin
            dec_cls[C_LOGIC] = 1'b1;
            dec_we           = 1'b1;
        end else if (opc_n == 32'h16 || opc_n == 32'h17) begin
            dec_cls[C_SET] = 1'b1;
            dec_we         = 1'b1;
        end else if (opc_n == 32'h18) begin
            dec_cls[C_LD] = 1'b1;
            dec_we        = 1'b1;
        end else if (opc_n == 32'h19) begin
            dec_cls[C_ST] = 1'b1;
        end else if (opc_n >= 32'h1C && opc_n <= 32'h1F) begin
            dec_cls[C_BR] = 1'b1;
        end else if (opc_n >= 32'h20 && opc_n <= 32'h23) begin
            if (EN_EXT != 0) begin
                dec_cls[C_EXT] = 1'b1;
                dec_we         = 1'b1;
            end else begin
                dec_rsv = 1'b1;
            end
        end else begin
            dec_und = 1'b1;
        end
    end

    assign rs2_used = !f_i && ((dec_cls & RS2_CLS) != '0);

    // ID/EX register
    logic              vld_q;
    logic [7:0]        cls_q;
    logic              we_q, imm_sel_q, rsv_q, und_q;
    logic [W_RA-1:0]   rd_q, rs1_q, rs2_q;
    logic [W_INST-1:0] imm_q;
    logic [W_CNT-1:0]  stall_cnt_q;

    // Load in ID/EX whose destination the incoming instruction reads; rd==0 never conflicts
    logic hazard, run, accept;

    assign hazard = inst_vld_i && vld_q && cls_q[C_LD] && (rd_q != '0) &&
                    ((rd_q == f_rs1) || (rs2_used && (rd_q == f_rs2)));
    assign run    = (state_q == StRun);

    assign id_rdy_o = !rst && !flush_i && run && (!vld_q || ex_rdy_i) && !hazard;
    assign stall_o  = !rst && hazard && run && !flush_i;
    assign accept   = inst_vld_i && id_rdy_o;

    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = StRun;
        end else if (accept && (dec_und || dec_rsv)) begin
            // The offending instruction is still presented; nothing follows it until a flush
            state_d = StHalt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q     <= 1'b0;
            cls_q     <= '0;
            we_q      <= 1'b0;
            rd_q      <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            imm_q     <= '0;
            imm_sel_q <= 1'b0;
            rsv_q     <= 1'b0;
            und_q     <= 1'b0;
        end else if (flush_i) begin
            vld_q <= 1'b0;
        end else if (accept) begin
            vld_q     <= 1'b1;
            cls_q     <= dec_cls;
            we_q      <= dec_we;
            rd_q      <= f_rd;
            rs1_q     <= f_rs1;
            rs2_q     <= f_rs2;
            imm_q     <= f_imm;
            imm_sel_q <= f_i;
            rsv_q     <= dec_rsv;
            und_q     <= dec_und;
        end else if (vld_q && ex_rdy_i) begin
            // EX drained the entry and nothing replaced it: bubble
            vld_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (stall_o && (stall_cnt_q != {W_CNT{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + W_CNT'(1);
        end
    end

    assign vld_o       = vld_q;
    assign cls_o       = cls_q;
    assign we_o        = we_q;
    assign rd_o        = rd_q;
    assign rs1_o       = rs1_q;
    assign rs2_o       = rs2_q;
    assign imm_o       = imm_q;
    assign imm_sel_o   = imm_sel_q;
    assign rsv_o       = rsv_q;
    assign und_o       = und_q;
    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_id_decode_stage.sv
// Bench for id_decode_stage. u_dut uses default parameters; u_dut2 shares its inputs
// but enables the EXT class and uses a 2-bit stall counter.
module tb_id_decode_stage;

    logic        clk;
    logic        rst;
    logic [31:0] inst_i;
    logic        inst_vld_i;
    logic        flush_i;
    logic        ex_rdy_i;

    logic        id_rdy_o, vld_o, we_o, imm_sel_o, rsv_o, und_o, stall_o;
    logic [7:0]  cls_o;
    logic [4:0]  rd_o, rs1_o, rs2_o;
    logic [31:0] imm_o;
    logic [15:0] stall_cnt_o;

    logic        d2_id_rdy, d2_vld, d2_we, d2_imm_sel, d2_rsv, d2_und, d2_stall;
    logic [7:0]  d2_cls;
    logic [4:0]  d2_rd, d2_rs1, d2_rs2;
    logic [31:0] d2_imm;
    logic [1:0]  d2_cnt;

    id_decode_stage u_dut (
        .clk        (clk),
        .rst        (rst),
        .inst_i     (inst_i),
        .inst_vld_i (inst_vld_i),
        .id_rdy_o   (id_rdy_o),
        .flush_i    (flush_i),
        .ex_rdy_i   (ex_rdy_i),
        .vld_o      (vld_o),
        .cls_o      (cls_o),
        .we_o       (we_o),
        .rd_o       (rd_o),
        .rs1_o      (rs1_o),
        .rs2_o      (rs2_o),
        .imm_o      (imm_o),
        .imm_sel_o  (imm_sel_o),
        .rsv_o      (rsv_o),
        .und_o      (und_o),
        .stall_o    (stall_o),
        .stall_cnt_o(stall_cnt_o)
    );

    id_decode_stage #(
        .EN_EXT(1),
        .W_CNT (2)
    ) u_dut2 (
        .clk        (clk),
        .rst        (rst),
        .inst_i     (inst_i),
        .inst_vld_i (inst_vld_i),
        .id_rdy_o   (d2_id_rdy),
        .flush_i    (flush_i),
        .ex_rdy_i   (ex_rdy_i),
        .vld_o      (d2_vld),
        .cls_o      (d2_cls),
        .we_o       (d2_we),
        .rd_o       (d2_rd),
        .rs1_o      (d2_rs1),
        .rs2_o      (d2_rs2),
        .imm_o      (d2_imm),
        .imm_sel_o  (d2_imm_sel),
        .rsv_o      (d2_rsv),
        .und_o      (d2_und),
        .stall_o    (d2_stall),
        .stall_cnt_o(d2_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [7:0]  cls;
        logic        we;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        isel;
        logic        rsv;
        logic        und;
    } vec_t;

    vec_t exp_q[$];
    vec_t tbl[8];
    vec_t v_ld, v_add, v_ld0, v_add0, v_und, v_rsv;
    int   checks;
    int   errors;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: an entry is consumed when EX takes it at the coming edge
    task automatic mon();
        vec_t e;
        if (!rst && vld_o && ex_rdy_i && !flush_i) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got inst with rd=%0d cls=0x%0h, want none",
                         rd_o, cls_o);
            end else begin
                e = exp_q.pop_front();
                chk($sformatf("cls[%h]", e.inst), 32'(cls_o), 32'(e.cls));
                chk($sformatf("we[%h]", e.inst), 32'(we_o), 32'(e.we));
                chk($sformatf("rd[%h]", e.inst), 32'(rd_o), 32'(e.rd));
                chk($sformatf("rs1[%h]", e.inst), 32'(rs1_o), 32'(e.rs1));
                chk($sformatf("rs2[%h]", e.inst), 32'(rs2_o), 32'(e.rs2));
                chk($sformatf("imm[%h]", e.inst), imm_o, e.imm);
                chk($sformatf("imm_sel[%h]", e.inst), 32'(imm_sel_o), 32'(e.isel));
                chk($sformatf("rsv[%h]", e.inst), 32'(rsv_o), 32'(e.rsv));
                chk($sformatf("und[%h]", e.inst), 32'(und_o), 32'(e.und));
            end
        end
    endtask

    // Wait for the sampling (falling) edge and run the scoreboard
    task automatic nstep();
        @(negedge clk);
        mon();
    endtask

    task automatic cycle();
        nstep();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction until accepted (bounded); called just after a rising edge
    task automatic send(input vec_t v);
        bit ok;
        ok = 1'b0;
        inst_i     = v.inst;
        inst_vld_i = 1'b1;
        for (int k = 0; k < 20 && !ok; k++) begin
            nstep();
            if (id_rdy_o) begin
                exp_q.push_back(v);
                ok = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        inst_vld_i = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout[%h]: got no accept, want accept", v.inst);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        //        inst          cls    we    rd     rs1    rs2    imm            isel  rsv   und
        tbl[0] = '{32'h00184400, 8'h80, 1'b1, 5'd3,  5'd1,  5'd2,  32'h00000400, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{32'h90003FFF, 8'h40, 1'b1, 5'd0,  5'd0,  5'd31, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{32'h04000000, 8'h80, 1'b0, 5'd0,  5'd0,  5'd0,  32'h00000000, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{32'h0D08C200, 8'h20, 1'b1, 5'd1,  5'd3,  5'd1,  32'h00000200, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{32'h17000000, 8'h10, 1'b1, 5'd0,  5'd0,  5'd0,  32'h00000000, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{32'h99002000, 8'h04, 1'b0, 5'd0,  5'd0,  5'd16, 32'hFFFFE000, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{32'h1C000000, 8'h02, 1'b0, 5'd0,  5'd0,  5'd0,  32'h00000000, 1'b0, 1'b0, 1'b0};
        tbl[7] = '{32'h13FFFFFF, 8'h40, 1'b1, 5'd31, 5'd31, 5'd31, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
        v_ld   = '{32'h98284004, 8'h08, 1'b1, 5'd5,  5'd1,  5'd0,  32'h00000004, 1'b1, 1'b0, 1'b0};
        v_add  = '{32'h00314400, 8'h80, 1'b1, 5'd6,  5'd5,  5'd2,  32'h00000400, 1'b0, 1'b0, 1'b0};
        v_ld0  = '{32'h98004004, 8'h08, 1'b1, 5'd0,  5'd1,  5'd0,  32'h00000004, 1'b1, 1'b0, 1'b0};
        v_add0 = '{32'h00014400, 8'h80, 1'b1, 5'd0,  5'd5,  5'd2,  32'h00000400, 1'b0, 1'b0, 1'b0};
        v_und  = '{32'h14000000, 8'h00, 1'b0, 5'd0,  5'd0,  5'd0,  32'h00000000, 1'b0, 1'b0, 1'b1};
        v_rsv  = '{32'h20000000, 8'h00, 1'b0, 5'd0,  5'd0,  5'd0,  32'h00000000, 1'b0, 1'b1, 1'b0};

        rst        = 1'b1;
        inst_i     = 32'h00184400;
        inst_vld_i = 1'b1;
        flush_i    = 1'b0;
        ex_rdy_i   = 1'b1;

        // Reset
        @(posedge clk);
        #1;
        nstep();
        chk("rst_id_rdy", 32'(id_rdy_o), 32'd0);
        chk("rst_stall", 32'(stall_o), 32'd0);
        @(posedge clk);
        #1;
        rst        = 1'b0;
        inst_vld_i = 1'b0;
        nstep();
        chk("post_rst_vld", 32'(vld_o), 32'd0);
        chk("post_rst_cls", 32'(cls_o), 32'd0);
        chk("post_rst_cnt", 32'(stall_cnt_o), 32'd0);
        chk("post_rst_id_rdy", 32'(id_rdy_o), 32'd1);
        @(posedge clk);
        #1;

        // Decode table, back-to-back
        for (int i = 0; i < 8; i++) send(tbl[i]);
        repeat (2) cycle();

        // Load-use: exactly one bubble
        send(v_ld);
        inst_i     = v_add.inst;
        inst_vld_i = 1'b1;
        nstep();
        chk("lu_stall", 32'(stall_o), 32'd1);
        chk("lu_id_rdy", 32'(id_rdy_o), 32'd0);
        @(posedge clk);
        #1;
        nstep();
        chk("lu_bubble_vld", 32'(vld_o), 32'd0);
        chk("lu_bubble_stall", 32'(stall_o), 32'd0);
        chk("lu_after_id_rdy", 32'(id_rdy_o), 32'd1);
        if (id_rdy_o) exp_q.push_back(v_add);
        @(posedge clk);
        #1;
        inst_vld_i = 1'b0;
        cycle();
        chk("lu_cnt", 32'(stall_cnt_o), 32'd1);

        // Load to r0 never stalls
        send(v_ld0);
        send(v_add0);
        repeat (2) cycle();
        chk("r0_cnt", 32'(stall_cnt_o), 32'd1);

        // EX back-pressure freezes the register
        ex_rdy_i = 1'b0;
        send(tbl[0]);
        inst_i     = tbl[3].inst;
        inst_vld_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            nstep();
            chk("frz_id_rdy", 32'(id_rdy_o), 32'd0);
            chk("frz_vld", 32'(vld_o), 32'd1);
            chk("frz_rd", 32'(rd_o), 32'd3);
            @(posedge clk);
            #1;
        end
        ex_rdy_i = 1'b1;
        nstep();
        chk("drain_id_rdy", 32'(id_rdy_o), 32'd1);
        if (id_rdy_o) exp_q.push_back(tbl[3]);
        @(posedge clk);
        #1;
        inst_vld_i = 1'b0;
        cycle();

        // Undefined opcode halts until flushed
        send(v_und);
        inst_i     = tbl[0].inst;
        inst_vld_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            nstep();
            chk("und_halt_id_rdy", 32'(id_rdy_o), 32'd0);
            @(posedge clk);
            #1;
        end
        flush_i = 1'b1;
        nstep();
        chk("flush_id_rdy", 32'(id_rdy_o), 32'd0);
        chk("flush_stall", 32'(stall_o), 32'd0);
        @(posedge clk);
        #1;
        flush_i    = 1'b0;
        inst_vld_i = 1'b0;
        nstep();
        chk("unflush_vld", 32'(vld_o), 32'd0);
        chk("unflush_id_rdy", 32'(id_rdy_o), 32'd1);
        @(posedge clk);
        #1;

        // Opcode 0x20: reserved in u_dut, EXT in u_dut2
        send(v_rsv);
        nstep();
        chk("ext_cls", 32'(d2_cls), 32'h01);
        chk("ext_we", 32'(d2_we), 32'd1);
        chk("ext_rsv", 32'(d2_rsv), 32'd0);
        chk("ext_vld", 32'(d2_vld), 32'd1);
        chk("ext_id_rdy", 32'(d2_id_rdy), 32'd1);
        chk("rsv_halt_id_rdy", 32'(id_rdy_o), 32'd0);
        @(posedge clk);
        #1;
        flush_i = 1'b1;
        cycle();
        flush_i = 1'b0;
        nstep();
        chk("rsv_unflush_id_rdy", 32'(id_rdy_o), 32'd1);
        @(posedge clk);
        #1;

        // Held hazard counts every cycle; 2-bit counter saturates
        send(v_ld);
        ex_rdy_i   = 1'b0;
        inst_i     = v_add.inst;
        inst_vld_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            nstep();
            chk("hold_stall", 32'(stall_o), 32'd1);
            chk("hold_id_rdy", 32'(id_rdy_o), 32'd0);
            @(posedge clk);
            #1;
        end
        ex_rdy_i = 1'b1;
        nstep();
        chk("hold_last_stall", 32'(stall_o), 32'd1);
        @(posedge clk);
        #1;
        nstep();
        chk("hold_bubble_vld", 32'(vld_o), 32'd0);
        chk("hold_after_id_rdy", 32'(id_rdy_o), 32'd1);
        if (id_rdy_o) exp_q.push_back(v_add);
        @(posedge clk);
        #1;
        inst_vld_i = 1'b0;
        cycle();
        chk("cnt_total", 32'(stall_cnt_o), 32'd6);
        chk("cnt_saturated", 32'(d2_cnt), 32'd3);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
